valu_unit: RTL
==============

# valu_unit

Dragon Core vector ALU functional unit: the execute-side endpoint of the issue stage's `valu_valid`/`valu_ready` dispatch handshake. It accepts one packed-SIMD operation per handshake, executes it in one cycle or iteratively over several cycles, and returns a single-cycle writeback pulse carrying result and transaction ID to the scoreboard writeback port. It sits in the EX stage next to the ALU/LSU/FPU units.

## Interface
Parameters:
- `XLEN`, 32, datapath width; must be a multiple of 16; byte lanes `L = XLEN/8`.
- `TRANS_ID_BITS`, 3, scoreboard transaction ID width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: kill all accepted-but-not-written-back work.
- `valu_valid_i` in 1: dispatch request from issue.
- `valu_ready_o` out 1: unit can accept a dispatch this cycle.
- `operation_i` in 4: opcode.
- `operand_a_i` in XLEN: first source.
- `operand_b_i` in XLEN: second source.
- `trans_id_i` in TRANS_ID_BITS: scoreboard ID of the dispatched instruction.
- `valu_result_o` out XLEN: writeback data.
- `valu_trans_id_o` out TRANS_ID_BITS: writeback ID.
- `valu_valid_o` out 1: writeback valid, one-cycle pulse, no backpressure.

## Operation
- Handshake: an op is accepted when `valu_valid_i && valu_ready_o && !flush_i`.
- Opcodes, lane-wise, with lane 0 = bits [7:0]:
  - 0 VADD8: add, mod 2^8.
  - 1 VSUB8: a−b, mod 2^8.
  - 2 VADDS8: signed add, saturating to [−128, 127].
  - 3 VMAX8: signed max.
  - 4 VMIN8: signed min.
  - 5 VADD16: 16-bit lane add, mod 2^16.
  - 6 VSUB16: 16-bit lane subtract, mod 2^16.
  - 7 VDOT8: sum of signed 8×8 byte products over all L lanes. The accumulator is XLEN signed; the result is sign-extended.
  - 8–15: illegal; result 0, single-cycle.
- FSM states:
  - IDLE:
    - `valu_ready_o`=1.
    - Accepting a single-cycle op: register the result and ID, pulse valid next cycle, stay in IDLE.
    - Accepting VDOT8: latch operands and ID, clear `acc` and the lane counter `cnt` (width clog2(L)), go to BUSY.
  - BUSY:
    - `valu_ready_o`=0.
    - Each edge: `acc += sext(a[cnt])*sext(b[cnt])`, `cnt++`.
    - At the edge where `cnt==L-1`: register `acc`+final product as the result, assert valid, go to IDLE.
- Flush: `flush_i` high in cycle F forces IDLE, clears `cnt`/`acc`, ignores any handshake in F, and forces `valu_valid_o`=0 in F+1. `valu_valid_o` already high in F is not retracted.
- Reset: asynchronous to IDLE. `valu_valid_o`=0, `valu_result_o`=0, `valu_trans_id_o`=0, `cnt`=0, `acc`=0. `valu_ready_o`=1 as soon as reset deasserts.
- `valu_result_o`/`valu_trans_id_o` hold their last value when `valu_valid_o`=0.

## Timing
- Single-cycle ops: accepted in cycle N → `valu_valid_o`=1 in N+1 only. Throughput is 1 op/cycle; `valu_ready_o` stays 1.
- VDOT8: accepted in cycle N.
  - `valu_ready_o`=0 in cycles N+1..N+L.
  - `valu_valid_o`=1 in N+L+1, in which `valu_ready_o`=1 again.
  - With L=4: ready low for 4 cycles, valid in N+5.
- A new op accepted in the same cycle a writeback pulse is visible is legal; its own pulse follows per the latencies above.
- `valu_ready_o` is a function of the state register only, never of `valu_valid_i`.
- Reset asserted during BUSY: the op is dropped and no writeback is produced.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle → all outputs 0 immediately; after release `valu_ready_o`=1 and `valu_valid_o` stays 0 with no stimulus.
- VADD8 a=0x01FF7F80, b=0x01010101, id=5, cycle N → cycle N+1: valid=1, result=0x02008081, id=5; cycle N+2: valid=0.
- VADDS8 a=0x7F801020, b=0x0180F010 → result 0x7F800030 one cycle later. Then VMAX8 a=0x80017F00, b=0x7FFF8001 → 0x7F017F01.
- VDOT8 a=0x02FF0304, b=0x0305FE01, id=3:
  - `valu_ready_o` low for exactly 4 cycles.
  - valid in N+5 with result 0xFFFFFFFF (4−6−5+6=−1), id=3.
  - A `valu_valid_i` held high during BUSY is not accepted.
- Flush: start VDOT8, assert `flush_i` in the 2nd BUSY cycle → no writeback ever appears for it, and `valu_ready_o`=1 the next cycle. A following VADD16 a=0xFFFF0001, b=0x00010001 writes 0x00000002 one cycle later.
- Back-to-back: VSUB8/VADD16/illegal op 9 with ids 1,2,3 in consecutive cycles → three consecutive valid pulses, ids 1,2,3. The op-9 result is 0.

Source files
------------

// File: rtl/valu_unit.sv
// Vector ALU functional unit: packed-SIMD byte/halfword ops in one cycle,
// signed byte dot product iterated one lane per cycle, single-cycle
// writeback pulse to the scoreboard.
//
// state | meaning
// IDLE  | ready for dispatch; single-cycle ops complete from here
// BUSY  | VDOT8 in progress, one byte lane accumulated per cycle
module valu_unit #(
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valu_valid_i,
  output logic                     valu_ready_o,
  input  logic [3:0]               operation_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          valu_result_o,
  output logic [TRANS_ID_BITS-1:0] valu_trans_id_o,
  output logic                     valu_valid_o
);

  localparam int L     = XLEN / 8;
  localparam int H     = XLEN / 16;
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);

  localparam logic [3:0] OP_VADD8  = 4'd0;
  localparam logic [3:0] OP_VSUB8  = 4'd1;
  localparam logic [3:0] OP_VADDS8 = 4'd2;
  localparam logic [3:0] OP_VMAX8  = 4'd3;
  localparam logic [3:0] OP_VMIN8  = 4'd4;
  localparam logic [3:0] OP_VADD16 = 4'd5;
  localparam logic [3:0] OP_VSUB16 = 4'd6;
  localparam logic [3:0] OP_VDOT8  = 4'd7;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     accept;
  logic                     is_dot;
  logic                     last_lane;
  logic [XLEN-1:0]          single_res;
  logic [8:0]               sat_sum;
  logic [XLEN-1:0]          op_a;
  logic [XLEN-1:0]          op_b;
  logic [XLEN-1:0]          acc;
  logic [XLEN-1:0]          acc_sum;
  logic [XLEN-1:0]          prod_ext;
  logic signed [15:0]       prod;
  logic [7:0]               lane_a;
  logic [7:0]               lane_b;
  logic [CNT_W-1:0]         cnt;
  logic [TRANS_ID_BITS-1:0] dot_id;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [XLEN-1:0]          result_q;
  logic                     valid_q;

  assign accept    = valu_valid_i && valu_ready_o && !flush_i;
  assign is_dot    = (operation_i == OP_VDOT8);
  assign last_lane = (cnt == CNT_LAST);

  // Dot-product lane selected by the lane counter, signed product widened to XLEN
  assign lane_a   = op_a[{cnt, 3'b000} +: 8];
  assign lane_b   = op_b[{cnt, 3'b000} +: 8];
  assign prod     = $signed(lane_a) * $signed(lane_b);
  assign prod_ext = XLEN'(prod);
  assign acc_sum  = acc + prod_ext;

  // Lane-wise result of every single-cycle opcode; illegal opcodes yield zero
  always_comb begin
    single_res = '0;
    sat_sum    = '0;
    for (int i = 0; i < L; i++) begin
      sat_sum = {operand_a_i[8*i+7], operand_a_i[8*i +: 8]}
              + {operand_b_i[8*i+7], operand_b_i[8*i +: 8]};
      case (operation_i)
        OP_VADD8:  single_res[8*i +: 8] = operand_a_i[8*i +: 8] + operand_b_i[8*i +: 8];
        OP_VSUB8:  single_res[8*i +: 8] = operand_a_i[8*i +: 8] - operand_b_i[8*i +: 8];
        OP_VADDS8: begin
          // sign bits of the 9-bit sum disagree only on overflow
          if (sat_sum[8] != sat_sum[7])
            single_res[8*i +: 8] = sat_sum[8] ? 8'h80 : 8'h7F;
          else
            single_res[8*i +: 8] = sat_sum[7:0];
        end
        OP_VMAX8:  single_res[8*i +: 8] =
                     ($signed(operand_a_i[8*i +: 8]) > $signed(operand_b_i[8*i +: 8]))
                     ? operand_a_i[8*i +: 8] : operand_b_i[8*i +: 8];
        OP_VMIN8:  single_res[8*i +: 8] =
                     ($signed(operand_a_i[8*i +: 8]) < $signed(operand_b_i[8*i +: 8]))
                     ? operand_a_i[8*i +: 8] : operand_b_i[8*i +: 8];
        default: ;
      endcase
    end
    for (int j = 0; j < H; j++) begin
      case (operation_i)
        OP_VADD16: single_res[16*j +: 16] = operand_a_i[16*j +: 16] + operand_b_i[16*j +: 16];
        OP_VSUB16: single_res[16*j +: 16] = operand_a_i[16*j +: 16] - operand_b_i[16*j +: 16];
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_dot) state_nxt = BUSY;
      BUSY: if (last_lane) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // Outputs decoded from the state register only
  always_comb begin
    valu_ready_o = (state == IDLE);
  end

  // Datapath: operand latch, accumulator, writeback registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
      dot_id   <= '0;
      id_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (is_dot) begin
                op_a   <= operand_a_i;
                op_b   <= operand_b_i;
                dot_id <= trans_id_i;
                acc    <= '0;
                cnt    <= '0;
              end else begin
                result_q <= single_res;
                id_q     <= trans_id_i;
                valid_q  <= 1'b1;
              end
            end
          end
          BUSY: begin
            cnt <= cnt + 1'b1;
            if (last_lane) begin
              // final lane folds straight into the result register
              result_q <= acc_sum;
              id_q     <= dot_id;
              valid_q  <= 1'b1;
              acc      <= '0;
            end else begin
              acc <= acc_sum;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign valu_result_o   = result_q;
  assign valu_trans_id_o = id_q;
  assign valu_valid_o    = valid_q;

endmodule
